// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among several fetch units.
// One request is in flight at a time. The fetch unit is answered with a registered one-cycle ready pulse.
module program_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int SUM_BITS = IDX_BITS + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [IDX_BITS-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]                grant_q, grant_d;
    logic [NUM_CONSUMERS-1:0]           hold_q, hold_d;
    logic [NUM_CONSUMERS-1:0]           ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_d;
    logic                               mem_valid_d;
    logic [ADDR_BITS-1:0]               mem_address_d;

    logic [NUM_CONSUMERS-1:0] eligible;
    logic                     found;
    logic [IDX_BITS-1:0]      winner;
    logic [SUM_BITS-1:0]      cand_sum;
    logic [ADDR_BITS-1:0]     winner_address;

    // Held consumers have already been answered for the request they are still showing.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        eligible = consumer_read_valid & ~hold_q;
        found    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + SUM_BITS'(k);
            if (cand_sum >= SUM_BITS'(NUM_CONSUMERS)) begin
                cand_sum = cand_sum - SUM_BITS'(NUM_CONSUMERS);
            end
            if (!found && eligible[cand_sum[IDX_BITS-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[IDX_BITS-1:0];
            end
        end
    end

    always_comb begin
        winner_address = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (winner == IDX_BITS'(i)) begin
                winner_address = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        hold_d        = hold_q & consumer_read_valid;
        ready_d       = '0;
        data_d        = consumer_read_data;
        mem_valid_d   = mem_read_valid;
        mem_address_d = mem_read_address;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d       = winner;
                    mem_address_d = winner_address;
                    mem_valid_d   = 1'b1;
                    state_d       = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_read_ready) begin
                    // Setting hold after the clear above makes a simultaneous set win.
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (grant_q == IDX_BITS'(i)) begin
                            data_d[i*DATA_BITS +: DATA_BITS] = mem_read_data;
                            ready_d[i]                       = 1'b1;
                            hold_d[i]                        = 1'b1;
                        end
                    end
                    mem_valid_d = 1'b0;
                    rr_ptr_d    = (grant_q == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                             : grant_q + IDX_BITS'(1);
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            hold_q              <= '0;
            consumer_read_ready <= '0;
            // NOTE: the per-consumer data fields are plain flops, not a RAM, so they are reset like any other output.
            consumer_read_data  <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            hold_q              <= hold_d;
            consumer_read_ready <= ready_d;
            consumer_read_data  <= data_d;
            mem_read_valid      <= mem_valid_d;
            mem_read_address    <= mem_address_d;
        end
    end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Self-checking bench for program_mem_arbiter: table-driven single requests plus multi-cycle sequences.
// A memory model answers grants, and a scoreboard queue holds the expected {consumer, address, data} in grant order.
module tb_program_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        int          delay;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cvalid;
    logic [AW-1:0]   caddr [N];
    logic [N*AW-1:0] caddr_flat;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;

    program_mem_arbiter #(
        .NUM_CONSUMERS(N),
        .ADDR_BITS    (AW),
        .DATA_BITS    (DW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (cvalid),
        .consumer_read_address(caddr_flat),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        caddr_flat = '0;
        for (int i = 0; i < N; i++) caddr_flat[i*AW +: AW] = caddr[i];
    end

    int n_cmp = 0;
    int n_err = 0;

    exp_t            exp_q[$];
    logic [N*DW-1:0] exp_data = '0;
    logic            prev_mem_valid = 1'b0;
    logic [AW-1:0]   latched_addr = '0;
    int              served = 0;

    int   mem_delay = 0;
    int   wait_cnt  = 0;
    logic spurious  = 1'b0;

    logic [N-1:0] auto_en = '0;
    int           rem   [N];
    int           phase [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 8'h1A) return 16'hBEEF;
        return {a ^ 8'hA5, a};
    endfunction

    task automatic push_exp(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Outputs are sampled on the falling edge, half a cycle away from the active edge.
    task automatic monitor();
        logic exp_pulse;
        exp_t e;
        exp_pulse = mem_read_ready && prev_mem_valid && !reset;
        check("ready_timing", 64'(|consumer_read_ready), 64'(exp_pulse));
        if (reset) begin
            exp_q.delete();
            exp_data = '0;
            check("reset_mem_valid", 64'(mem_read_valid), 0);
        end else begin
            if (mem_read_valid && !prev_mem_valid) begin
                check("grant_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("grant_addr", 64'(mem_read_address), 64'(exp_q[0].addr));
                latched_addr = mem_read_address;
            end else if (mem_read_valid) begin
                check("addr_stable", 64'(mem_read_address), 64'(latched_addr));
            end
            if (consumer_read_ready != '0) begin
                check("ready_onehot", 64'($onehot(consumer_read_ready)), 1);
                check("ready_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ready_idx", 64'(consumer_read_ready), 64'(N'(1) << e.idx));
                    check("ready_data", 64'(consumer_read_data[e.idx*DW +: DW]), 64'(e.data));
                    exp_data[e.idx*DW +: DW] = e.data;
                    served++;
                end
            end
        end
        check("data_hold", 64'(consumer_read_data), 64'(exp_data));
        prev_mem_valid = mem_read_valid;
    endtask

    task automatic mem_model();
        if (spurious) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_read_valid ? mem_fn(mem_read_address) : 16'hDEAD;
        end else if (mem_read_valid && !mem_read_ready) begin
            if (wait_cnt >= mem_delay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_fn(mem_read_address);
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_read_ready = 1'b0;
            mem_read_data  = '0;
            wait_cnt       = 0;
        end
    endtask

    // Auto fetch unit: valid stays high one cycle after ready, drops, then re-requests while rem > 0.
    task automatic consumer_model();
        for (int i = 0; i < N; i++) begin
            if (auto_en[i]) begin
                case (phase[i])
                    0: if (consumer_read_ready[i]) phase[i] = 1;
                    1: begin cvalid[i] = 1'b0; phase[i] = 2; end
                    default: begin
                        if (rem[i] > 0) begin rem[i]--; cvalid[i] = 1'b1; end
                        phase[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        mem_model();
        consumer_model();
    endtask

    task automatic wait_served(input int target, input int budget, input string name);
        int t = 0;
        while (served < target && t < budget) begin
            tick();
            t++;
        end
        check(name, 64'(served), 64'(target));
    endtask

    task automatic start_auto(input logic [N-1:0] mask, input int r0, input int r1, input int r2, input int r3);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
        for (int i = 0; i < N; i++) phase[i] = 0;
        auto_en = mask;
        cvalid  = mask;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   s0;
        int   t;

        vecs[0] = '{2, 8'h1A, 2, 16'hBEEF};
        vecs[1] = '{0, 8'h00, 0, 16'hA500};
        vecs[2] = '{1, 8'hFF, 1, 16'h5AFF};
        vecs[3] = '{3, 8'hC0, 3, 16'h65C0};
        vecs[4] = '{2, 8'h33, 0, 16'h9633};
        vecs[5] = '{3, 8'h81, 0, 16'h2481};

        reset          = 1'b1;
        cvalid         = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        for (int i = 0; i < N; i++) begin
            caddr[i] = '0;
            rem[i]   = 0;
            phase[i] = 0;
        end

        repeat (2) tick();
        check("reset_mem_address", 64'(mem_read_address), 0);
        check("reset_ready", 64'(consumer_read_ready), 0);
        check("reset_data", 64'(consumer_read_data), 0);
        reset = 1'b0;
        tick();

        // Single requesters, one table row each; the last row leaves rr_ptr at 0.
        for (int v = 0; v < 6; v++) begin
            mem_delay          = vecs[v].delay;
            caddr[vecs[v].idx] = vecs[v].addr;
            push_exp(vecs[v].idx, vecs[v].addr, vecs[v].exp_data);
            cvalid[vecs[v].idx] = 1'b1;
            wait_served(served + 1, 40, "vec_served");
            cvalid[vecs[v].idx] = 1'b0;
            repeat (3) tick();
        end

        // Round-robin fairness with continuous re-requests: order 0,1,2,3,0,1.
        mem_delay = 0;
        for (int i = 0; i < N; i++) caddr[i] = 8'h40 + 8'(i);
        for (int k = 0; k < 6; k++) push_exp(k % N, 8'h40 + 8'(k % N), mem_fn(8'h40 + 8'(k % N)));
        start_auto(4'b1111, 1, 1, 0, 0);
        wait_served(served + 6, 200, "rr_served");
        repeat (4) tick();
        auto_en = '0;
        cvalid  = '0;
        tick();

        // Hold mask: stale valid after ready is not re-granted, even with memory ready asserted idly.
        spurious = 1'b1;
        caddr[0] = 8'h77;
        push_exp(0, 8'h77, mem_fn(8'h77));
        cvalid[0] = 1'b1;
        wait_served(served + 1, 40, "hold_first");
        s0 = served;
        repeat (6) tick();
        check("hold_no_regrant", 64'(served), 64'(s0));
        check("hold_mem_idle", 64'(mem_read_valid), 0);
        cvalid[0] = 1'b0;
        tick();
        caddr[0] = 8'h78;
        push_exp(0, 8'h78, mem_fn(8'h78));
        cvalid[0] = 1'b1;
        wait_served(served + 1, 40, "hold_second");
        cvalid[0] = 1'b0;
        spurious  = 1'b0;
        repeat (3) tick();

        // Pointer wrap: serve consumer 2, then 3 beats 0; afterwards rr_ptr=1 makes 1 beat 0.
        caddr[2] = 8'h22;
        push_exp(2, 8'h22, mem_fn(8'h22));
        cvalid[2] = 1'b1;
        wait_served(served + 1, 40, "wrap_c2");
        cvalid[2] = 1'b0;
        repeat (3) tick();
        caddr[0] = 8'h30;
        caddr[3] = 8'h33;
        push_exp(3, 8'h33, mem_fn(8'h33));
        push_exp(0, 8'h30, mem_fn(8'h30));
        start_auto(4'b1001, 0, 0, 0, 0);
        wait_served(served + 2, 60, "wrap_c3_c0");
        repeat (4) tick();
        caddr[0] = 8'h50;
        caddr[1] = 8'h51;
        push_exp(1, 8'h51, mem_fn(8'h51));
        push_exp(0, 8'h50, mem_fn(8'h50));
        start_auto(4'b0011, 0, 0, 0, 0);
        wait_served(served + 2, 60, "wrap_ptr_one");
        repeat (4) tick();
        auto_en = '0;
        cvalid  = '0;

        // Reset while memory is stalled in WAIT_MEM.
        mem_delay = 100;
        caddr[2]  = 8'h99;
        push_exp(2, 8'h99, mem_fn(8'h99));
        cvalid[2] = 1'b1;
        t = 0;
        while (!mem_read_valid && t < 20) begin
            tick();
            t++;
        end
        check("rst_granted", 64'(mem_read_valid), 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        s0 = served;
        check("rst_ready", 64'(consumer_read_ready), 0);
        check("rst_mem_valid", 64'(mem_read_valid), 0);
        check("rst_data", 64'(consumer_read_data), 0);
        reset     = 1'b0;
        cvalid    = '0;
        mem_delay = 0;
        spurious  = 1'b1;
        repeat (3) tick();
        spurious = 1'b0;
        tick();
        check("rst_ignored_mem_ready", 64'(served), 64'(s0));
        caddr[0] = 8'h01;
        caddr[1] = 8'h02;
        push_exp(0, 8'h01, mem_fn(8'h01));
        push_exp(1, 8'h02, mem_fn(8'h02));
        start_auto(4'b0011, 0, 0, 0, 0);
        wait_served(served + 2, 60, "rst_ptr_zero");
        repeat (4) tick();
        auto_en = '0;
        cvalid  = '0;

        // Stalled memory: address wiggles and valid drops mid-wait; the grant still completes.
        mem_delay = 10;
        caddr[3]  = 8'h3C;
        push_exp(3, 8'h3C, mem_fn(8'h3C));
        cvalid[3] = 1'b1;
        s0 = served;
        for (int k = 0; k < 40 && served == s0; k++) begin
            tick();
            caddr[3] = 8'($urandom);
            if (k == 3) cvalid[3] = 1'b0;
        end
        check("stall_served", 64'(served), 64'(s0 + 1));
        repeat (2) tick();
        mem_delay = 0;
        caddr[3]  = 8'h3D;
        push_exp(3, 8'h3D, mem_fn(8'h3D));
        cvalid[3] = 1'b1;
        wait_served(served + 1, 40, "stall_hold_cleared");
        cvalid[3] = 1'b0;
        repeat (5) tick();

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
